// File: rtl/stream_pkg.sv
// Shared definitions for the stream primitives: default element width,
// default FIFO depth and a constant-evaluable clog2.
package stream_pkg;

    localparam int INT_N = 8;
    localparam int STREAM_FIFO_DEPTH_DEFAULT = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x N register array: one synchronous write port, one combinational
// read port. Data is deliberately left unreset.
module stream_fifo_mem
    import stream_pkg::*;
#(
    parameter int N     = INT_N,
    parameter int DEPTH = STREAM_FIFO_DEPTH_DEFAULT,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready elastic buffer feeding the stream-unpacking primitives.
// Optional macro STREAM_FIFO_COUNT_EN exposes the occupancy as port count.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int N     = INT_N,
    parameter int DEPTH = STREAM_FIFO_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    flush,
    input  logic [N-1:0]            sIn,
    input  logic                    sIn_valid,
    output logic                    sIn_ready,
    output logic [N-1:0]            sOut,
    output logic                    sOut_valid,
`ifdef STREAM_FIFO_COUNT_EN
    input  logic                    sOut_ready,
    output logic [clog2(DEPTH):0]   count
`else
    input  logic                    sOut_ready
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    // Ready depends on stored state only, so a full FIFO refuses a push even
    // when the consumer frees an entry in the same cycle.
    assign sIn_ready  = (cnt != CW'(DEPTH));
    assign sOut_valid = (cnt != '0);
    assign push       = sIn_valid && sIn_ready;
    assign pop        = sOut_valid && sOut_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wr <= wr + AW'(1);
            end
            if (pop) begin
                rd <= rd + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    stream_fifo_mem #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr),
        .wdata (sIn),
        .raddr (rd),
        .rdata (sOut)
    );

`ifdef STREAM_FIFO_COUNT_EN
    assign count = cnt;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Randomised and directed bench for stream_fifo with a queue-based
// reference model and a negedge monitor acting as scoreboard.
module tb_stream_fifo;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic         clk;
    logic         nrst;
    logic         flush;
    logic [N-1:0] sIn;
    logic         sIn_valid;
    logic         sIn_ready;
    logic [N-1:0] sOut;
    logic         sOut_valid;
    logic         sOut_ready;
`ifdef STREAM_FIFO_COUNT_EN
    logic [2:0]   count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;

    logic [N-1:0] q [$];
    logic         prev_stall = 1'b0;
    logic [N-1:0] prev_data  = '0;

    stream_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .flush      (flush),
        .sIn        (sIn),
        .sIn_valid  (sIn_valid),
        .sIn_ready  (sIn_ready),
        .sOut       (sOut),
        .sOut_valid (sOut_valid),
`ifdef STREAM_FIFO_COUNT_EN
        .sOut_ready (sOut_ready),
        .count      (count)
`else
        .sOut_ready (sOut_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: flags are compared against the model occupancy, then the
    // handshakes seen this cycle update the model.
    always @(negedge clk) begin
        if (!nrst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready", 32'(sIn_ready), 32'(q.size() != DEPTH));
            check("out_valid", 32'(sOut_valid), 32'(q.size() != 0));
`ifdef STREAM_FIFO_COUNT_EN
            check("count", 32'(count), 32'(q.size()));
`endif
            if (prev_stall) begin
                check("stall_valid", 32'(sOut_valid), 32'd1);
                check("stall_data", 32'(sOut), 32'(prev_data));
            end
            prev_stall = sOut_valid && !sOut_ready && !flush;
            prev_data  = sOut;
            if (flush) begin
                q.delete();
            end else begin
                if (sOut_valid && sOut_ready) begin
                    pops++;
                    if (q.size() == 0) begin
                        check("pop_nonempty", 32'(q.size()), 32'd1);
                    end else begin
                        check("data", 32'(sOut), 32'(q.pop_front()));
                    end
                end
                if (sIn_valid && sIn_ready) begin
                    q.push_back(sIn);
                end
            end
        end
    end

    initial begin
        int v;
        int p0;
        int budget;
        logic acc;

        nrst = 1'b0; flush = 1'b0; sIn = '0; sIn_valid = 1'b0; sOut_ready = 1'b0;
        #12;
        check("rst_valid", 32'(sOut_valid), 32'd0);
        check("rst_ready", 32'(sIn_ready), 32'd1);
        step();
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_valid", 32'(sOut_valid), 32'd0);
            check("idle_ready", 32'(sIn_ready), 32'd1);
        end

        // Single push into empty FIFO
        sOut_ready = 1'b1; sIn = 8'h05; sIn_valid = 1'b1;
        step();
        sIn_valid = 1'b0;
        check("single_valid", 32'(sOut_valid), 32'd1);
        check("single_data", 32'(sOut), 32'h5);
        step();
        check("single_gone", 32'(sOut_valid), 32'd0);

        // Fill to full, offer a fifth element
        sOut_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sIn = 8'(i); sIn_valid = 1'b1;
            step();
        end
        check("full_ready", 32'(sIn_ready), 32'd0);
        sIn = 8'd5;
        step(); step();
        check("full_hold_ready", 32'(sIn_ready), 32'd0);
        check("full_head", 32'(sOut), 32'd1);
        sOut_ready = 1'b1;
        p0 = pops;
        budget = 0;
        while (sIn_valid && budget < 10) begin
            acc = sIn_valid && sIn_ready;
            step();
            if (acc) sIn_valid = 1'b0;
            budget++;
        end
        check("fifth_accepted", 32'(sIn_valid), 32'd0);
        repeat (6) step();
        check("fill_pops", 32'(pops - p0), 32'd5);

        // Streaming with wrap-around
        p0 = pops;
        for (int i = 1; i <= 20; i++) begin
            sIn = 8'(i); sIn_valid = 1'b1;
            check("stream_ready", 32'(sIn_ready), 32'd1);
            step();
        end
        sIn_valid = 1'b0;
        check("stream_tail", 32'(sOut), 32'd20);
        step();
        check("stream_pops", 32'(pops - p0), 32'd20);

        // Consumer stalling every other cycle
        p0 = pops;
        v = 1;
        budget = 0;
        while (v <= 8 && budget < 64) begin
            sIn = 8'(v); sIn_valid = 1'b1;
            sOut_ready = budget[0] ? 1'b0 : 1'b1;
            acc = sIn_ready;
            step();
            if (acc) v++;
            budget++;
        end
        sIn_valid = 1'b0;
        check("stall_done", 32'(v), 32'd9);
        for (int i = 0; i < 20; i++) begin
            sOut_ready = i[0];
            step();
        end
        check("stall_pops", 32'(pops - p0), 32'd8);

        // Flush with three entries stored
        sOut_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sIn = 8'(8'hA0 + i); sIn_valid = 1'b1;
            step();
        end
        sIn_valid = 1'b1; sIn = 8'hEE; flush = 1'b1;
        step();
        flush = 1'b0; sIn_valid = 1'b0;
        check("flush_valid", 32'(sOut_valid), 32'd0);
        check("flush_ready", 32'(sIn_ready), 32'd1);
`ifdef STREAM_FIFO_COUNT_EN
        check("flush_count", 32'(count), 32'd0);
`endif

        // Asynchronous reset while full
        for (int i = 0; i < 4; i++) begin
            sIn = 8'(8'h30 + i); sIn_valid = 1'b1;
            step();
        end
        sIn_valid = 1'b0;
        check("pre_rst_ready", 32'(sIn_ready), 32'd0);
        #2 nrst = 1'b0;
        #1;
        check("arst_valid", 32'(sOut_valid), 32'd0);
        check("arst_ready", 32'(sIn_ready), 32'd1);
        step();
        nrst = 1'b1;
        step();

        // Randomised traffic with occasional flush
        for (int i = 0; i < 2000; i++) begin
            sIn        = 8'($urandom);
            sIn_valid  = ($urandom_range(0, 3) != 0);
            sOut_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 63) == 0);
            step();
        end
        flush = 1'b0; sIn_valid = 1'b0; sOut_ready = 1'b1;
        repeat (8) step();
        check("drain_valid", 32'(sOut_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
